// File: rtl/toy_pack.sv
// ============================================================================
//  Module   : toy_pack
//  Purpose  : Shared types and constants for the dispatch issue scheduler.
//             Holds the scheduler state encoding and the FU type enumeration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package toy_pack;

    // Index of the CSR unit for the default four-port configuration
    localparam int FU_CSR_IDX = 3;

    // Scheduler serialisation state: CSR_BUSY holds off all issue
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CSR_BUSY = 1'b1
    } sched_state_e;

    // Functional unit type codes carried with each buffer slot
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_MUL = 2'd2,
        FU_CSR = 2'd3
    } fu_type_t;

endpackage

`default_nettype wire

// File: rtl/toy_issue_credit_cnt.sv
// ============================================================================
//  Module   : toy_issue_credit_cnt
//  Purpose  : Per-FU in-flight credit counter. Decrements on issue, increments
//             on return, saturates at CREDIT_NUM and flags an over-return.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toy_issue_credit_cnt #(
    parameter int CREDIT_NUM = 4,
    localparam int CNT_W     = $clog2(CREDIT_NUM + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_ret,
    output logic o_credit_nz
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CREDIT_NUM);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_credit;

    // Credit update; issue and return together cancel out, return at max saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= C_MAX;
        end else begin
            assert (!(i_ret && !i_issue && (r_credit == C_MAX)))
                else $warning("credit return while credit already at maximum");
            if (i_issue && !i_ret) begin
                r_credit <= r_credit - C_ONE;
            end else if (i_ret && !i_issue && (r_credit != C_MAX)) begin
                r_credit <= r_credit + C_ONE;
            end
        end
    end

    assign o_credit_nz = (r_credit != '0);

endmodule

`default_nettype wire

// File: rtl/toy_dispatch_issue_sched.sv
// ============================================================================
//  Module   : toy_dispatch_issue_sched
//  Purpose  : Issue scheduler between the dispatch issue buffer and the FUs.
//             Picks the oldest eligible slot per FU, gated by per-FU credits
//             and a CSR serialisation FSM. Grant path is combinational.
//  Config   : TOY_ISSUE_SCHED_PERF_EN adds per-FU stall counters (v_perf_stall)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toy_dispatch_issue_sched
    import toy_pack::*;
#(
    parameter int OOO_DEPTH  = 4,
    parameter int FU_NUM     = 4,
    parameter int CREDIT_NUM = 4,
    localparam int FU_W      = $clog2(FU_NUM),
    localparam int OOO_W     = $clog2(OOO_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [OOO_DEPTH-1:0]                v_s_vld,
    output logic [OOO_DEPTH-1:0]                v_s_rdy,
    input  logic [OOO_DEPTH-1:0][FU_W-1:0]      v_s_fu_type,
    output logic [FU_NUM-1:0]                   v_m_vld,
    input  logic [FU_NUM-1:0]                   v_m_rdy,
    output logic [FU_NUM-1:0][OOO_W-1:0]        v_m_slot_idx,
    input  logic [FU_NUM-1:0]                   v_credit_ret,
    input  logic                                csr_done,
    input  logic                                cancel_edge_en
`ifdef TOY_ISSUE_SCHED_PERF_EN
   ,output logic [FU_NUM-1:0][31:0]             v_perf_stall
`endif
);

    localparam int               C_CSR      = FU_NUM - 1;
    localparam logic [FU_W-1:0]  C_CSR_TYPE = FU_W'(FU_NUM - 1);

    sched_state_e               r_state;
    sched_state_e               w_state_nxt;
    logic [OOO_DEPTH-1:0]       w_struct_ok;
    logic [OOO_DEPTH-1:0]       w_elig;
    logic [FU_NUM-1:0]          w_found;
    logic [FU_NUM-1:0][OOO_W-1:0] w_sel;
    logic [FU_NUM-1:0]          w_credit_nz;
    logic [FU_NUM-1:0]          w_issue;
    logic                       w_csr_seen;

    // Slot eligibility: nothing passes an older CSR, and a CSR only goes from slot 0
    always_comb begin
        w_struct_ok = '0;
        w_elig      = '0;
        w_csr_seen  = 1'b0;
        for (int i = 0; i < OOO_DEPTH; i++) begin
            w_struct_ok[i] = v_s_vld[i] && !w_csr_seen &&
                             ((v_s_fu_type[i] != C_CSR_TYPE) || (i == 0));
            w_elig[i]      = w_struct_ok[i] && (r_state == IDLE) && !cancel_edge_en;
            w_csr_seen     = w_csr_seen || (v_s_vld[i] && (v_s_fu_type[i] == C_CSR_TYPE));
        end
    end

    // Per-FU oldest-first selection; scanning downward leaves the lowest index
    always_comb begin
        w_found = '0;
        w_sel   = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            for (int i = OOO_DEPTH - 1; i >= 0; i--) begin
                if (w_elig[i] && (v_s_fu_type[i] == FU_W'(f))) begin
                    w_found[f] = 1'b1;
                    w_sel[f]   = OOO_W'(i);
                end
            end
        end
    end

    // Grant outputs; v_m_vld is independent of v_m_rdy, v_s_rdy reflects actual issue
    always_comb begin
        v_m_vld      = '0;
        v_s_rdy      = '0;
        w_issue      = '0;
        v_m_slot_idx = w_sel;
        for (int f = 0; f < FU_NUM; f++) begin
            v_m_vld[f] = !rst && w_found[f] && w_credit_nz[f];
            w_issue[f] = v_m_vld[f] && v_m_rdy[f];
            if (w_issue[f]) begin
                v_s_rdy[w_sel[f]] = 1'b1;
            end
        end
    end

    // One credit counter per FU port
    generate
        for (genvar f = 0; f < FU_NUM; f++) begin : g_credit
            toy_issue_credit_cnt #(
                .CREDIT_NUM (CREDIT_NUM)
            ) u_credit (
                .clk         (clk),
                .rst         (rst),
                .i_issue     (w_issue[f]),
                .i_ret       (v_credit_ret[f]),
                .o_credit_nz (w_credit_nz[f])
            );
        end
    endgenerate

    // CSR serialisation next state; cancel always lands in IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (cancel_edge_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_issue[C_CSR]) w_state_nxt = CSR_BUSY;
                CSR_BUSY: if (csr_done)       w_state_nxt = IDLE;
                default:                      w_state_nxt = IDLE;
            endcase
        end
    end

    // CSR serialisation state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef TOY_ISSUE_SCHED_PERF_EN
    logic [FU_NUM-1:0]        w_cand;
    logic [FU_NUM-1:0][31:0]  r_perf;

    // Candidate per FU ignores FSM and cancel gating so CSR_BUSY stalls are visible
    always_comb begin
        w_cand = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            for (int i = 0; i < OOO_DEPTH; i++) begin
                if (w_struct_ok[i] && (v_s_fu_type[i] == FU_W'(f))) begin
                    w_cand[f] = 1'b1;
                end
            end
        end
    end

    // Stall counters: candidate present but blocked by empty credit or CSR_BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else begin
            for (int f = 0; f < FU_NUM; f++) begin
                if (w_cand[f] && (!w_credit_nz[f] || (r_state == CSR_BUSY))) begin
                    r_perf[f] <= r_perf[f] + 32'd1;
                end
            end
        end
    end

    assign v_perf_stall = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_toy_dispatch_issue_sched.sv
// ============================================================================
//  Module   : tb_toy_dispatch_issue_sched
//  Purpose  : Directed self-checking bench for toy_dispatch_issue_sched.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_toy_dispatch_issue_sched;

    localparam logic [1:0] ALU = 2'd0;
    localparam logic [1:0] LSU = 2'd1;
    localparam logic [1:0] CSR = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       v_s_vld;
    logic [3:0]       v_s_rdy;
    logic [3:0][1:0]  v_s_fu_type;
    logic [3:0]       v_m_vld;
    logic [3:0]       v_m_rdy;
    logic [3:0][1:0]  v_m_slot_idx;
    logic [3:0]       v_credit_ret;
    logic             csr_done;
    logic             cancel_edge_en;
`ifdef TOY_ISSUE_SCHED_PERF_EN
    logic [3:0][31:0] v_perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    toy_dispatch_issue_sched dut (
        .clk            (clk),
        .rst            (rst),
        .v_s_vld        (v_s_vld),
        .v_s_rdy        (v_s_rdy),
        .v_s_fu_type    (v_s_fu_type),
        .v_m_vld        (v_m_vld),
        .v_m_rdy        (v_m_rdy),
        .v_m_slot_idx   (v_m_slot_idx),
        .v_credit_ret   (v_credit_ret),
        .csr_done       (csr_done),
        .cancel_edge_en (cancel_edge_en)
`ifdef TOY_ISSUE_SCHED_PERF_EN
       ,.v_perf_stall   (v_perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; v_s_vld = '0; v_s_fu_type = '0; v_m_rdy = 4'hF;
        v_credit_ret = '0; csr_done = 1'b0; cancel_edge_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1; v_m_rdy = 4'hF; v_credit_ret = '0; csr_done = 1'b0; cancel_edge_en = 1'b0;
        v_s_vld = 4'hF; v_s_fu_type = {ALU, LSU, ALU, ALU};
        tick(); settle();
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL reset_vld got=%b exp=0000", v_m_vld); end
        total++; if (v_s_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", v_s_rdy); end
        rst = 1'b0; settle();
        total++; if (v_m_vld !== 4'b0011) begin bad++; $display("FAIL sel_vld got=%b exp=0011", v_m_vld); end
        total++; if (v_m_slot_idx[0] !== 2'd0) begin bad++; $display("FAIL sel_alu_idx got=%0d exp=0", v_m_slot_idx[0]); end
        total++; if (v_m_slot_idx[1] !== 2'd2) begin bad++; $display("FAIL sel_lsu_idx got=%0d exp=2", v_m_slot_idx[1]); end
        total++; if (v_s_rdy !== 4'b0101) begin bad++; $display("FAIL sel_srdy got=%b exp=0101", v_s_rdy); end
        total++; if (v_m_slot_idx[2] !== 2'd0) begin bad++; $display("FAIL sel_idle_idx got=%0d exp=0", v_m_slot_idx[2]); end
        v_m_rdy = 4'b0000; settle();
        total++; if (v_m_vld !== 4'b0011) begin bad++; $display("FAIL vld_no_rdy got=%b exp=0011", v_m_vld); end
        total++; if (v_s_rdy !== 4'b0000) begin bad++; $display("FAIL srdy_no_rdy got=%b exp=0000", v_s_rdy); end
        v_m_rdy = 4'hF;
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, ALU}; settle();
        for (int k = 0; k < 4; k++) begin
            total++; if (v_m_vld[0] !== 1'b1) begin bad++; $display("FAIL exhaust_issue%0d got=%b exp=1", k, v_m_vld[0]); end
            tick();
        end
        total++; if (v_m_vld[0] !== 1'b0) begin bad++; $display("FAIL exhaust_block got=%b exp=0", v_m_vld[0]); end
        v_credit_ret = 4'b0001; settle();
        total++; if (v_m_vld[0] !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", v_m_vld[0]); end
        tick(); v_credit_ret = '0; settle();
        total++; if (v_m_vld[0] !== 1'b1 || v_s_rdy !== 4'b0001) begin
            bad++; $display("FAIL resume got vld=%b srdy=%b exp vld=1 srdy=0001", v_m_vld[0], v_s_rdy); end
        tick();
        total++; if (v_m_vld[0] !== 1'b0) begin bad++; $display("FAIL reexhaust got=%b exp=0", v_m_vld[0]); end
        v_s_vld = '0;
    endtask

    task automatic test_csr_serial();
        do_reset();
        v_s_vld = 4'b0011; v_s_fu_type = {ALU, LSU, ALU, CSR}; v_m_rdy = 4'b0000; settle();
        total++; if (v_m_vld !== 4'b1000) begin bad++; $display("FAIL csr_head_blocks got=%b exp=1000", v_m_vld); end
        v_m_rdy = 4'hF;
        v_s_vld = 4'b0111; v_s_fu_type = {ALU, LSU, CSR, ALU}; settle();
        total++; if (v_m_vld !== 4'b0001 || v_s_rdy !== 4'b0001) begin
            bad++; $display("FAIL csr_older_only got vld=%b srdy=%b exp vld=0001 srdy=0001", v_m_vld, v_s_rdy); end
        tick();
        v_s_vld = 4'b0011; v_s_fu_type = {ALU, ALU, LSU, CSR}; settle();
        total++; if (v_m_vld !== 4'b1000 || v_m_slot_idx[3] !== 2'd0 || v_s_rdy !== 4'b0001) begin
            bad++; $display("FAIL csr_issue got vld=%b idx=%0d srdy=%b exp vld=1000 idx=0 srdy=0001", v_m_vld, v_m_slot_idx[3], v_s_rdy); end
        tick();
        v_s_vld = 4'b0001; v_s_fu_type = {ALU, ALU, ALU, LSU}; settle();
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL csr_busy1 got=%b exp=0000", v_m_vld); end
        tick();
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL csr_busy2 got=%b exp=0000", v_m_vld); end
        csr_done = 1'b1; settle();
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL csr_done_cycle got=%b exp=0000", v_m_vld); end
        tick(); csr_done = 1'b0; settle();
        total++; if (v_m_vld !== 4'b0010 || v_m_slot_idx[1] !== 2'd0 || v_s_rdy !== 4'b0001) begin
            bad++; $display("FAIL after_csr got vld=%b idx=%0d srdy=%b exp vld=0010 idx=0 srdy=0001", v_m_vld, v_m_slot_idx[1], v_s_rdy); end
        v_s_vld = '0;
    endtask

    task automatic test_credit_balance();
        do_reset();
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, ALU};
        tick(); tick();
        v_credit_ret = 4'b0001; settle();
        total++; if (v_m_vld[0] !== 1'b1) begin bad++; $display("FAIL balance_issue got=%b exp=1", v_m_vld[0]); end
        tick(); v_credit_ret = '0; settle();
        for (int k = 0; k < 2; k++) begin
            total++; if (v_m_vld[0] !== 1'b1) begin bad++; $display("FAIL balance_left%0d got=%b exp=1", k, v_m_vld[0]); end
            tick();
        end
        total++; if (v_m_vld[0] !== 1'b0) begin bad++; $display("FAIL balance_empty got=%b exp=0", v_m_vld[0]); end
        do_reset();
        v_credit_ret = 4'b0001; tick(); v_credit_ret = '0;
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, ALU};
        tick(); tick(); tick(); tick(); settle();
        total++; if (v_m_vld[0] !== 1'b0) begin bad++; $display("FAIL saturate got=%b exp=0", v_m_vld[0]); end
        v_s_vld = '0;
    endtask

    task automatic test_cancel();
        do_reset();
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, ALU}; tick();
        v_s_fu_type = {LSU, LSU, LSU, CSR}; tick();
        v_s_fu_type = {LSU, LSU, LSU, ALU}; cancel_edge_en = 1'b1; settle();
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL cancel_cycle got=%b exp=0000", v_m_vld); end
        tick(); cancel_edge_en = 1'b0; settle();
        for (int k = 0; k < 3; k++) begin
            total++; if (v_m_vld !== 4'b0001) begin bad++; $display("FAIL cancel_idle%0d got=%b exp=0001", k, v_m_vld); end
            tick();
        end
        total++; if (v_m_vld !== 4'b0000) begin bad++; $display("FAIL cancel_credit got=%b exp=0000", v_m_vld); end
        do_reset();
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, CSR}; tick();
        v_s_fu_type = {LSU, LSU, LSU, LSU}; csr_done = 1'b1; cancel_edge_en = 1'b1; tick();
        csr_done = 1'b0; cancel_edge_en = 1'b0; settle();
        total++; if (v_m_vld !== 4'b0010) begin bad++; $display("FAIL done_and_cancel got=%b exp=0010", v_m_vld); end
        v_s_vld = '0;
    endtask

`ifdef TOY_ISSUE_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        v_s_vld = 4'b0001; v_s_fu_type = {LSU, LSU, LSU, ALU};
        for (int k = 0; k < 7; k++) tick();
        v_s_vld = '0; settle();
        total++; if (v_perf_stall[0] !== 32'd3) begin bad++; $display("FAIL perf_alu got=%0d exp=3", v_perf_stall[0]); end
        total++; if (v_perf_stall[1] !== 32'd0) begin bad++; $display("FAIL perf_lsu got=%0d exp=0", v_perf_stall[1]); end
        tick();
        total++; if (v_perf_stall[0] !== 32'd3) begin bad++; $display("FAIL perf_hold got=%0d exp=3", v_perf_stall[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_credit_exhaust();
        test_csr_serial();
        test_credit_balance();
        test_cancel();
`ifdef TOY_ISSUE_SCHED_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
